// File: rtl/vld_rdy_rr_arb.sv
// vld_rdy_rr_arb: round-robin arbiter feeding one registered
// valid/ready output stage shared by NUM_REQ requesters.
module vld_rdy_rr_arb #(
   parameter int NUM_REQ   = 4,
   parameter int DW        = 32,
   parameter int CUT_READY = 0,
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_vld_i,
   input  logic [NUM_REQ*DW-1:0] req_data_i,
   output logic [NUM_REQ-1:0]    req_rdy_o,
   output logic                  vld_o,
   output logic [DW-1:0]         data_o,
   output logic [IW-1:0]         id_o,
   input  logic                  rdy_i
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [IW-1:0]  ptr_q;
   logic [IW-1:0]  id_q;
   logic [DW-1:0]  data_q;
   logic [IW-1:0]  gnt;
   logic [IW-1:0]  gnt_nxt;
   logic [DW-1:0]  gnt_data;
   logic           gnt_vld;
   logic           pop;
   logic           can_acc;
   logic           push;
   int             scan_idx;
   logic [DW-1:0]  req_data [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_data[k] = req_data_i[k*DW +: DW];
   end

   assign vld_o   = (state_q == FULL);
   assign pop     = vld_o & rdy_i;
   assign can_acc = (CUT_READY != 0) ? ~vld_o : (~vld_o | pop);
   assign push    = can_acc & gnt_vld;
   assign data_o  = data_q;
   assign id_o    = id_q;

   // Scan from ptr upward with wrap; walking backwards lets the
   // first hit in scan order be the last assignment to win.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt      = '0;
      gnt_nxt  = '0;
      gnt_data = '0;
      scan_idx = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_idx = int'(ptr_q) + i;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (req_vld_i[scan_idx[IW-1:0]]) begin
            gnt_vld  = 1'b1;
            gnt      = scan_idx[IW-1:0];
            gnt_data = req_data[scan_idx[IW-1:0]];
            gnt_nxt  = (scan_idx + 1 == NUM_REQ) ? '0
                                                 : IW'(scan_idx + 1);
         end
      end
   end

   // Ready goes only to the granted requester when the stage can take it.
   always_comb begin
      req_rdy_o = '0;
      if (push) req_rdy_o[gnt] = 1'b1;
   end

   // Stage occupancy: fill on push, drain on a pop without refill.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (push) state_d = FULL;
         FULL:  if (pop && !push) state_d = EMPTY;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Capture winner payload/index and advance the priority pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
         id_q   <= '0;
         ptr_q  <= '0;
      end else if (push) begin
         data_q <= gnt_data;
         id_q   <= gnt;
         ptr_q  <= gnt_nxt;
      end
   end

endmodule

// File: tb/tb_vld_rdy_rr_arb.sv
// tb_vld_rdy_rr_arb: directed checks of the round-robin stage
// for NUM_REQ=4 (both ready modes) and NUM_REQ=3 wrap.
module tb_vld_rdy_rr_arb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // main: NUM_REQ=4, CUT_READY=0
   logic [3:0]   m_vld;
   logic [127:0] m_data;
   logic [3:0]   m_rdy;
   logic         m_ovld;
   logic [31:0]  m_odata;
   logic [1:0]   m_id;
   logic         m_ordy;

   // cut: NUM_REQ=4, CUT_READY=1
   logic [3:0]   c_vld;
   logic [127:0] c_data;
   logic [3:0]   c_rdy;
   logic         c_ovld;
   logic [31:0]  c_odata;
   logic [1:0]   c_id;
   logic         c_ordy;

   // three: NUM_REQ=3, CUT_READY=0
   logic [2:0]   t_vld;
   logic [95:0]  t_data;
   logic [2:0]   t_rdy;
   logic         t_ovld;
   logic [31:0]  t_odata;
   logic [1:0]   t_id;
   logic         t_ordy;

   int n_chk  = 0;
   int n_pass = 0;

   vld_rdy_rr_arb #(.NUM_REQ(4), .DW(32), .CUT_READY(0)) u_main (
      .clk(clk), .rst_n(rst_n),
      .req_vld_i(m_vld), .req_data_i(m_data), .req_rdy_o(m_rdy),
      .vld_o(m_ovld), .data_o(m_odata), .id_o(m_id), .rdy_i(m_ordy)
   );

   vld_rdy_rr_arb #(.NUM_REQ(4), .DW(32), .CUT_READY(1)) u_cut (
      .clk(clk), .rst_n(rst_n),
      .req_vld_i(c_vld), .req_data_i(c_data), .req_rdy_o(c_rdy),
      .vld_o(c_ovld), .data_o(c_odata), .id_o(c_id), .rdy_i(c_ordy)
   );

   vld_rdy_rr_arb #(.NUM_REQ(3), .DW(32), .CUT_READY(0)) u_three (
      .clk(clk), .rst_n(rst_n),
      .req_vld_i(t_vld), .req_data_i(t_data), .req_rdy_o(t_rdy),
      .vld_o(t_ovld), .data_o(t_odata), .id_o(t_id), .rdy_i(t_ordy)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // edge, then 1ns so inputs change away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      m_vld  = '0; m_ordy = 1'b0;
      c_vld  = '0; c_ordy = 1'b0;
      t_vld  = '0; t_ordy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_data[k*32 +: 32] = 32'h1000 + k;
         c_data[k*32 +: 32] = 32'h2000 + k;
      end
      for (int k = 0; k < 3; k++) t_data[k*32 +: 32] = 32'h3000 + k;
      step();
      step();

      chk("rst_vld",  64'(m_ovld),  64'd0);
      chk("rst_id",   64'(m_id),    64'd0);
      chk("rst_data", 64'(m_odata), 64'd0);
      chk("rst_rdy",  64'(m_rdy),   64'd0);
      chk("rst_cvld", 64'(c_ovld),  64'd0);

      // 1: all valid, rdy_i=1 -> ids 0,1,2,3,0 back to back
      rst_n  = 1'b1;
      m_vld  = 4'b1111;
      m_ordy = 1'b1;
      #1;
      chk("t1_rdy0", 64'(m_rdy), 64'b0001);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t1_vld",  64'(m_ovld),  64'd1);
         chk("t1_id",   64'(m_id),    64'(i % 4));
         chk("t1_data", 64'(m_odata), 64'(32'h1000 + (i % 4)));
      end

      // 2: lone requester 2, same-cycle ready; ptr then 3
      m_vld = 4'b0100;
      m_data[2*32 +: 32] = 32'hA5A5_0002;
      #1;
      chk("t2_rdy", 64'(m_rdy), 64'b0100);
      step();
      chk("t2_vld",  64'(m_ovld),  64'd1);
      chk("t2_data", 64'(m_odata), 64'hA5A5_0002);
      chk("t2_id",   64'(m_id),    64'd2);
      m_vld = 4'b0000;
      step();
      chk("t2_drain", 64'(m_ovld), 64'd0);
      m_ordy = 1'b0;
      m_vld  = 4'b1111;
      #1;
      chk("t2_ptr3", 64'(m_rdy), 64'b1000);

      // 3: hold FULL id 1 under backpressure, then pop+push
      m_vld = 4'b0010;
      #1;
      chk("t3_fill_rdy", 64'(m_rdy), 64'b0010);
      step();
      m_vld = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_bp_rdy",  64'(m_rdy),   64'd0);
         chk("t3_bp_id",   64'(m_id),    64'd1);
         chk("t3_bp_data", 64'(m_odata), 64'h1001);
         step();
      end
      chk("t3_bp_vld", 64'(m_ovld), 64'd1);
      m_ordy = 1'b1;
      #1;
      chk("t3_pp_rdy", 64'(m_rdy), 64'b1000);
      step();
      chk("t3_pp_vld",  64'(m_ovld),  64'd1);
      chk("t3_pp_id",   64'(m_id),    64'd3);
      chk("t3_pp_data", 64'(m_odata), 64'h1003);
      m_vld = 4'b0000;
      step();
      chk("t3_drain", 64'(m_ovld), 64'd0);

      // 4: CUT_READY=1 -> one beat every other cycle
      c_vld  = 4'b1111;
      c_ordy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t4_vld", 64'(c_ovld), 64'((i % 2) == 0));
         if ((i % 2) == 0) begin
            chk("t4_id",   64'(c_id),    64'(i / 2));
            chk("t4_data", 64'(c_odata), 64'(32'h2000 + i / 2));
            chk("t4_rdy_full", 64'(c_rdy), 64'd0);
         end
      end
      c_vld = 4'b0000;

      // 5: ptr=3 with req 0011 -> wrap to 0, then 1
      m_vld = 4'b0100;
      step();
      m_vld = 4'b0011;
      #1;
      chk("t5_rdy0", 64'(m_rdy), 64'b0001);
      step();
      chk("t5_id0", 64'(m_id), 64'd0);
      chk("t5_rdy1", 64'(m_rdy), 64'b0010);
      step();
      chk("t5_id1", 64'(m_id), 64'd1);
      m_vld = 4'b0000;
      step();

      // 5b: NUM_REQ=3 wraps at 3, not at 4
      t_ordy = 1'b1;
      t_vld  = 3'b010;
      step();
      t_vld = 3'b001;
      #1;
      chk("t5_n3_rdy", 64'(t_rdy), 64'b001);
      step();
      chk("t5_n3_id0", 64'(t_id),    64'd0);
      chk("t5_n3_dat", 64'(t_odata), 64'h3000);
      t_vld = 3'b100;
      step();
      chk("t5_n3_id2", 64'(t_id), 64'd2);
      t_vld = 3'b011;
      #1;
      chk("t5_n3_wrap", 64'(t_rdy), 64'b001);
      t_vld = 3'b000;

      // 6: reset mid-stream with the stage FULL
      m_vld  = 4'b1110;
      m_ordy = 1'b0;
      step();
      chk("t6_full", 64'(m_ovld), 64'd1);
      chk("t6_id",   64'(m_id),   64'd2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t6_vld",  64'(m_ovld),  64'd0);
      chk("t6_id0",  64'(m_id),    64'd0);
      chk("t6_data", 64'(m_odata), 64'd0);
      #1;
      chk("t6_gnt", 64'(m_rdy), 64'b0010);
      step();
      chk("t6_post_id", 64'(m_id), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
